mult16_seq_ctrl: RTL

- Upstream sequencer for the 16x16 shift-add multiplier.
- Accepts operand pairs on a valid/ready interface and clears the multiplier through its active-low reset before each operation.
- Holds mul_start high until mul_done, then captures mul_yout into a small result FIFO.
- Results leave on a valid/ready interface in acceptance order.

---
 rtl/mult16_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mult16_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult16_seq_ctrl
// Upstream sequencer for the 16x16 shift-add multiplier.
//  - Accepts operand pairs on a valid/ready interface.
//  - Clears the multiplier through mul_rst_n for one cycle before every
//    operation (the multiplier never clears its own accumulator).
//  - Holds mul_start until mul_done, then pushes mul_yout into a small result
//    FIFO that drains on a valid/ready interface in acceptance order.
//
// Optional build macro: MULT_SEQ_TIMEOUT_EN
//  - When defined, a RUN-state watchdog of TIMEOUT_CYC cycles abandons an
//    operation that never completes and pulses timeout_err for one cycle.
//  - When undefined, there is no watchdog and no timeout_err port.
// -----------------------------------------------------------------------------
module mult16_seq_ctrl #(
   parameter int RES_DEPTH   = 2,
   parameter int TIMEOUT_CYC = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        mul_rst_n,
   output logic        mul_start,
   output logic [15:0] mul_ain,
   output logic [15:0] mul_bin,
   input  logic [31:0] mul_yout,
   input  logic        mul_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_y
`ifdef MULT_SEQ_TIMEOUT_EN
   ,
   output logic        timeout_err
`endif
);

   // ---------------------------------------------------------------------
   // Local constants
   // ---------------------------------------------------------------------
   localparam int PTR_W = $clog2(RES_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RES_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CLR  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // Reject configurations the FIFO pointer arithmetic cannot support.
   if ((RES_DEPTH < 2) || ((RES_DEPTH & (RES_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("mult16_seq_ctrl: RES_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("mult16_seq_ctrl: TIMEOUT_CYC must be at least 1");
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [15:0]       ain_q;
   logic [15:0]       ain_d;
   logic [15:0]       bin_q;
   logic [15:0]       bin_d;
   logic              mul_rst_n_q;
   logic              mul_rst_n_d;
   logic              mul_start_q;
   logic              mul_start_d;
   logic              in_ready_q;
   logic              in_ready_d;

   logic [31:0]       mem_q [RES_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [31:0]       out_y_q;
   logic [31:0]       out_y_d;

   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              timeout_s;
   logic [31:0]       head_s;

   // ---------------------------------------------------------------------
   // Handshake qualifiers
   // ---------------------------------------------------------------------
   // in_ready_q is only ever set for IDLE, the state test keeps it explicit.
   assign accept_s = in_valid & in_ready_q & (state_q == ST_IDLE);
   // mul_done is only meaningful while an operation is running.
   assign push_s   = (state_q == ST_RUN) & mul_done;
   assign pop_s    = out_valid_q & out_ready;

`ifdef MULT_SEQ_TIMEOUT_EN
   // ---------------------------------------------------------------------
   // RUN-state watchdog
   // ---------------------------------------------------------------------
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   logic [TMO_W-1:0]  tmo_cnt_q;
   logic [TMO_W-1:0]  tmo_cnt_d;
   logic              timeout_err_q;

   // Fires in the last permitted RUN cycle if the multiplier is still busy.
   assign timeout_s = (state_q == ST_RUN) & ~mul_done & (tmo_cnt_q == TMO_LAST);

   // Watchdog next count: zero outside RUN so every RUN entry starts at 0.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_RUN) begin
         tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      end else begin
         tmo_cnt_d = {TMO_W{1'b0}};
      end
   end

   // Watchdog counter and one-cycle error pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q     <= {TMO_W{1'b0}};
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_s;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_s = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------
   // Next state: IDLE -> CLR on acceptance, CLR -> RUN always, RUN -> IDLE
   // on completion (or watchdog expiry when built in).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_CLR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mul_done || timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand capture and registered multiplier / input-side controls.
   always_comb begin
      if (accept_s) begin
         ain_d = in_a;
         bin_d = in_b;
      end else begin
         ain_d = ain_q;
         bin_d = bin_q;
      end
      // The multiplier is held in reset exactly while we sit in CLR.
      mul_rst_n_d = (state_d != ST_CLR);
      mul_start_d = (state_d == ST_RUN);
      // A full FIFO only blocks new work; a running operation still completes.
      in_ready_d  = (state_d == ST_IDLE) && (count_d != DEPTH_C);
   end

   // Sequencer state, operand and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ain_q       <= 16'd0;
         bin_q       <= 16'd0;
         mul_rst_n_q <= 1'b0;
         mul_start_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ain_q       <= ain_d;
         bin_q       <= bin_d;
         mul_rst_n_q <= mul_rst_n_d;
         mul_start_q <= mul_start_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // ---------------------------------------------------------------------
   // Result FIFO
   // ---------------------------------------------------------------------
   // Pointer and occupancy update; push and pop together leave count as is.
   always_comb begin
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Registered head: the entry at the next read pointer, including a value
   // being written this very cycle into that slot.
   always_comb begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_s = mul_yout;
      end else begin
         head_s = mem_q[rd_ptr_d];
      end
      out_valid_d = (count_d != CNT_ZERO);
      if (out_valid_d) begin
         out_y_d = head_s;
      end else begin
         out_y_d = 32'd0;
      end
   end

   // FIFO storage, pointers and registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RES_DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= CNT_ZERO;
         out_valid_q <= 1'b0;
         out_y_q     <= 32'd0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= mul_yout;
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign in_ready  = in_ready_q;
   assign mul_rst_n = mul_rst_n_q;
   assign mul_start = mul_start_q;
   assign mul_ain   = ain_q;
   assign mul_bin   = bin_q;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;

endmodule
